// File: rtl/seg7_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package seg7_pkg;

   typedef enum logic [1:0] {IDLE, SHOW, GUARD} state_t;

   localparam int         NIBBLE_W       = 4;
   localparam int         MAX_DIGITS     = 16;
   localparam logic [4:0] SEG_BLANK_CODE = 5'h10;

   // Bit i set when digits i..num_digits-1 are all zero; digit 0 is never blanked.
   function automatic logic [MAX_DIGITS-1:0] lz_mask(
      input logic [NIBBLE_W*MAX_DIGITS-1:0] value,
      input int                             num_digits
   );
      logic all_zero;
      all_zero = 1'b1;
      lz_mask  = '0;
      for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
         if (i < num_digits) begin
            all_zero   = all_zero & (value[i*NIBBLE_W +: NIBBLE_W] == '0);
            lz_mask[i] = all_zero;
         end
      end
   endfunction

endpackage

// File: rtl/hex_display.sv
// Hex-to-7-segment decoder (abcdefg, MSB = a, active-high); codes >= 5'h10 are dark.
module hex_display (
   input  logic [4:0] src,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'b0000000;
      case (src)
         5'h00: seg = 7'b1111110;
         5'h01: seg = 7'b0110000;
         5'h02: seg = 7'b1101101;
         5'h03: seg = 7'b1111001;
         5'h04: seg = 7'b0110011;
         5'h05: seg = 7'b1011011;
         5'h06: seg = 7'b1011111;
         5'h07: seg = 7'b1110000;
         5'h08: seg = 7'b1111111;
         5'h09: seg = 7'b1111011;
         5'h0A: seg = 7'b1110111;
         5'h0B: seg = 7'b0011111;
         5'h0C: seg = 7'b1001110;
         5'h0D: seg = 7'b0111101;
         5'h0E: seg = 7'b1001111;
         5'h0F: seg = 7'b1000111;
         default: seg = 7'b0000000;
      endcase
   end

endmodule

// File: rtl/seg7_scan_controller.sv
// Time-multiplexed scan of an N-digit hex value with guard slots, leading-zero
// blanking and a one-deep pending buffer swapped in only at frame boundaries.
module seg7_scan_controller
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS   = 8,
   parameter int PRESCALE     = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           enable,
   input  logic                           lz_blank_en,
   input  logic [NIBBLE_W*NUM_DIGITS-1:0] in_value,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic [NUM_DIGITS-1:0]          digit_en,
   output logic [6:0]                     segment,
   output logic                           frame_done
);

   localparam int VAL_W   = NIBBLE_W * NUM_DIGITS;
   localparam int EXT_W   = NIBBLE_W * MAX_DIGITS;
   localparam int IDX_W   = $clog2(NUM_DIGITS);
   localparam int MASK_IW = $clog2(MAX_DIGITS);
   localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX);

   state_t                  state, state_n;
   logic [CNT_W-1:0]        presc, presc_n;
   logic [IDX_W-1:0]        idx, idx_n;
   logic [VAL_W-1:0]        display, display_n, pending;
   logic                    pending_full, lz_q, lz_n;
   logic                    wrap, xfer, accept, blank;
   logic [NIBBLE_W-1:0]     nibble;
   logic [MAX_DIGITS-1:0]   mask;
   logic [4:0]              src;
   logic [6:0]              seg_dec;

   assign in_ready = !pending_full;
   assign accept   = in_valid && !pending_full;

   always_comb begin
      state_n = state;
      presc_n = presc;
      idx_n   = idx;
      wrap    = 1'b0;
      if (!enable) begin
         state_n = IDLE;
         presc_n = '0;
         idx_n   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_n = SHOW;
               presc_n = '0;
               idx_n   = '0;
            end
            SHOW: begin
               if (presc == CNT_W'(PRESCALE - 1)) begin
                  state_n = GUARD;
                  presc_n = '0;
               end else begin
                  presc_n = presc + 1'b1;
               end
            end
            GUARD: begin
               if (presc == CNT_W'(BLANK_CYCLES - 1)) begin
                  state_n = SHOW;
                  presc_n = '0;
                  if (idx == IDX_W'(NUM_DIGITS - 1)) begin
                     idx_n = '0;
                     wrap  = 1'b1;
                  end else begin
                     idx_n = idx + 1'b1;
                  end
               end else begin
                  presc_n = presc + 1'b1;
               end
            end
            default: begin
               state_n = IDLE;
               presc_n = '0;
               idx_n   = '0;
            end
         endcase
      end
   end

   // Outputs are decoded from next-cycle values so that the registered
   // digit_en and segment update together with the state they describe.
   assign xfer      = pending_full && ((state == IDLE) || wrap);
   assign display_n = xfer ? pending : display;
   assign lz_n      = (state_n == SHOW && state != SHOW) ? lz_blank_en : lz_q;
   assign mask      = lz_mask(EXT_W'(display_n), NUM_DIGITS);
   assign nibble    = display_n[int'(idx_n)*NIBBLE_W +: NIBBLE_W];
   assign blank     = lz_n && mask[MASK_IW'(idx_n)];
   assign src       = blank ? SEG_BLANK_CODE : {1'b0, nibble};

   hex_display u_hex_display (
      .src (src),
      .seg (seg_dec)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         presc        <= '0;
         idx          <= '0;
         display      <= '0;
         pending      <= '0;
         pending_full <= 1'b0;
         lz_q         <= 1'b0;
         digit_en     <= '0;
         segment      <= '0;
         frame_done   <= 1'b0;
      end else begin
         state      <= state_n;
         presc      <= presc_n;
         idx        <= idx_n;
         display    <= display_n;
         lz_q       <= lz_n;
         frame_done <= wrap;
         if (accept) begin
            pending      <= in_value;
            pending_full <= 1'b1;
         end else if (xfer) begin
            pending_full <= 1'b0;
         end
         if (state_n == SHOW) begin
            digit_en <= NUM_DIGITS'(1) << idx_n;
            segment  <= seg_dec;
         end else begin
            digit_en <= '0;
            segment  <= '0;
         end
      end
   end

endmodule
